// File: rtl/data_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : data_mem_ctrl                                                 |
// | Purpose  : Sequencer between the CPU load/store stage and a word-wide    |
// |            data RAM. Handles one request at a time. Sub-word loads are   |
// |            sign- or zero-extended. Byte and halfword stores use a        |
// |            read-modify-write. Misaligned or illegal accesses are flagged |
// |            without touching memory.                                      |
// | Ports    : clk, rst           clock, synchronous active-high reset       |
// |            req_*              request handshake and payload             |
// |            rsp_*              response handshake and payload            |
// |            ram_de/we/a/wd/rd  word RAM pins (ram_rd valid same cycle)    |
// |            busy               controller not idle                        |
// |            stat_*             saturating counters                        |
// | Options  : DATA_MEM_CTRL_STATS_EN enables the statistics counters.       |
// |            When it is undefined the stat ports are tied to zero.         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module data_mem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  ram_de,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [DATA_WIDTH-1:0] ram_wd,
  input  logic [DATA_WIDTH-1:0] ram_rd,
  output logic                  busy,
  output logic [STAT_WIDTH-1:0] stat_loads,
  output logic [STAT_WIDTH-1:0] stat_stores,
  output logic [STAT_WIDTH-1:0] stat_errs
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  store_q;
  logic [2:0]            funct3_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] merged_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic                  accept;
  logic                  req_bad;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_ext;
  logic [DATA_WIDTH-1:0] merged;

  assign accept = req_valid && req_ready;

  // Alignment and funct3 legality, evaluated on the live request so the
  // decision is made in the acceptance cycle. Unsigned widths are load-only.
  always_comb begin
    req_bad = 1'b0;
    case (req_funct3)
      F3_B:    req_bad = 1'b0;
      F3_H:    req_bad = req_addr[0];
      F3_W:    req_bad = |req_addr[1:0];
      F3_BU:   req_bad = req_store;
      F3_HU:   req_bad = req_store | req_addr[0];
      default: req_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_bad)               state_nx = RESP;
          else if (!req_store)       state_nx = LOAD;
          else if (req_funct3 == F3_W) state_nx = WRITE;
          else                       state_nx = RMW_RD;
        end
      end
      LOAD:    state_nx = RESP;
      RMW_RD:  state_nx = WRITE;
      WRITE:   state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Lane selection and extension of the RAM read word for loads.
  always_comb begin
    ld_byte = ram_rd[8*addr_q[1:0] +: 8];
    ld_half = ram_rd[16*addr_q[1] +: 16];
    case (funct3_q)
      F3_B:    ld_ext = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      F3_BU:   ld_ext = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      F3_H:    ld_ext = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      F3_HU:   ld_ext = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      default: ld_ext = ram_rd;
    endcase
  end

  // Read-modify-write merge: replace only the target lane of the old word.
  always_comb begin
    merged = ram_rd;
    if (funct3_q == F3_B) merged[8*addr_q[1:0] +: 8]  = wdata_q[7:0];
    else                  merged[16*addr_q[1] +: 16]  = wdata_q[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q   <= req_addr;
            store_q  <= req_store;
            funct3_q <= req_funct3;
            wdata_q  <= req_wdata;
            rdata_q  <= '0;
            err_q    <= req_bad;
          end
        end
        LOAD:   rdata_q  <= ld_ext;
        RMW_RD: merged_q <= merged;
        WRITE: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // RAM pins are forced to zero outside the memory-access states; the write
  // strobe is also gated by rst so an abort during WRITE never commits.
  assign ram_de = (state == LOAD) || (state == RMW_RD) || (state == WRITE);
  assign ram_we = (state == WRITE) && !rst;
  assign ram_a  = ram_de ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign ram_wd = (state == WRITE) ? ((funct3_q == F3_W) ? wdata_q : merged_q) : '0;

`ifdef DATA_MEM_CTRL_STATS_EN
  logic [STAT_WIDTH-1:0] cnt_loads, cnt_stores, cnt_errs;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_loads  <= '0;
      cnt_stores <= '0;
      cnt_errs   <= '0;
    end else begin
      if (state == LOAD && cnt_loads != '1)
        cnt_loads <= cnt_loads + STAT_WIDTH'(1);
      if (state == WRITE && store_q && cnt_stores != '1)
        cnt_stores <= cnt_stores + STAT_WIDTH'(1);
      if (accept && req_bad && cnt_errs != '1)
        cnt_errs <= cnt_errs + STAT_WIDTH'(1);
    end
  end

  assign stat_loads  = cnt_loads;
  assign stat_stores = cnt_stores;
  assign stat_errs   = cnt_errs;
`else
  assign stat_loads  = '0;
  assign stat_stores = '0;
  assign stat_errs   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_data_mem_ctrl                                              |
// | Purpose  : Self-checking bench for data_mem_ctrl with a behavioural      |
// |            16-word RAM at 0x10000 and a response scoreboard.             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_data_mem_ctrl;
  localparam int STATW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, req_store;
  logic [2:0]       req_funct3;
  logic [31:0]      req_addr, req_wdata;
  logic             rsp_valid, rsp_ready, rsp_err;
  logic [31:0]      rsp_rdata;
  logic             ram_de, ram_we;
  logic [31:0]      ram_a, ram_wd, ram_rd;
  logic             busy;
  logic [STATW-1:0] stat_loads, stat_stores, stat_errs;

  data_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STAT_WIDTH(STATW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .ram_de(ram_de), .ram_we(ram_we), .ram_a(ram_a), .ram_wd(ram_wd),
    .ram_rd(ram_rd), .busy(busy),
    .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: word index from ram_a[5:2], read data combinational.
  logic [31:0] mem [0:15];
  logic        preset;
  int          de_cnt = 0;
  int          wr_cnt = 0;
  int          bad_pin = 0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;

  assign ram_rd = mem[ram_a[5:2]];

  always @(posedge clk) begin
    if (preset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h8001_7F80;
    end else if (ram_de && ram_we) begin
      mem[ram_a[5:2]] <= ram_wd;
      last_wa <= ram_a;
      last_wd <= ram_wd;
    end
    if (ram_de) de_cnt <= de_cnt + 1;
    if (ram_de && ram_we) wr_cnt <= wr_cnt + 1;
    if (ram_de && (ram_a[31:6] != 26'h400 || ram_a[1:0] != 2'b00)) bad_pin <= bad_pin + 1;
    if (!ram_de && (ram_we || ram_a != 32'h0 || ram_wd != 32'h0)) bad_pin <= bad_pin + 1;
  end

  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          de;
    int          we;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  vec_t vecs [20];
  exp_t sbq [$];

  int errors = 0;
  int checks = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v, input int idx);
    int   lat;
    int   de0, we0;
    exp_t e;
    @(negedge clk);
    check32($sformatf("req_ready[%0d]", idx), {31'b0, req_ready}, 32'd1);
    de0        = de_cnt;
    we0        = wr_cnt;
    req_valid  = 1'b1;
    req_store  = v.store;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    sbq.push_back('{v.rdata, v.err, v.lat});
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    e = sbq.pop_front();
    check32($sformatf("rdata[%0d]", idx), rsp_rdata, e.rdata);
    check32($sformatf("err[%0d]", idx), {31'b0, rsp_err}, {31'b0, e.err});
    check32($sformatf("latency[%0d]", idx), 32'(lat), 32'(e.lat));
    check32($sformatf("de_cycles[%0d]", idx), 32'(de_cnt - de0), 32'(v.de));
    check32($sformatf("we_cycles[%0d]", idx), 32'(wr_cnt - we0), 32'(v.we));
  endtask

  function automatic logic [STATW-1:0] sat(input int n);
    return (n > 3) ? 2'd3 : STATW'(n);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_ld, n_st, n_er, we0;

    //            st   f3      addr          wdata         rdata         err  lat de we
    vecs[0]  = '{1'b0, 3'b000, 32'h0001_0000, 32'h0,        32'hFFFF_FF80, 1'b0, 2, 1, 0};
    vecs[1]  = '{1'b0, 3'b100, 32'h0001_0000, 32'h0,        32'h0000_0080, 1'b0, 2, 1, 0};
    vecs[2]  = '{1'b0, 3'b001, 32'h0001_0002, 32'h0,        32'hFFFF_8001, 1'b0, 2, 1, 0};
    vecs[3]  = '{1'b0, 3'b101, 32'h0001_0002, 32'h0,        32'h0000_8001, 1'b0, 2, 1, 0};
    vecs[4]  = '{1'b0, 3'b001, 32'h0001_0000, 32'h0,        32'h0000_7F80, 1'b0, 2, 1, 0};
    vecs[5]  = '{1'b0, 3'b000, 32'h0001_0001, 32'h0,        32'h0000_007F, 1'b0, 2, 1, 0};
    vecs[6]  = '{1'b0, 3'b010, 32'h0001_0000, 32'h0,        32'h8001_7F80, 1'b0, 2, 1, 0};
    vecs[7]  = '{1'b1, 3'b010, 32'h0001_0000, 32'h1122_3344, 32'h0,        1'b0, 2, 1, 1};
    vecs[8]  = '{1'b1, 3'b000, 32'h0001_0001, 32'h0000_55AA, 32'h0,        1'b0, 3, 2, 1};
    vecs[9]  = '{1'b0, 3'b010, 32'h0001_0000, 32'h0,        32'h1122_AA44, 1'b0, 2, 1, 0};
    vecs[10] = '{1'b1, 3'b001, 32'h0001_0002, 32'hFFFF_BEEF, 32'h0,        1'b0, 3, 2, 1};
    vecs[11] = '{1'b0, 3'b010, 32'h0001_0000, 32'h0,        32'hBEEF_AA44, 1'b0, 2, 1, 0};
    vecs[12] = '{1'b1, 3'b010, 32'h0001_0004, 32'hDEAD_BEEF, 32'h0,        1'b0, 2, 1, 1};
    vecs[13] = '{1'b0, 3'b010, 32'h0001_0004, 32'h0,        32'hDEAD_BEEF, 1'b0, 2, 1, 0};
    vecs[14] = '{1'b0, 3'b010, 32'h0001_0002, 32'h0,        32'h0,         1'b1, 1, 0, 0};
    vecs[15] = '{1'b1, 3'b001, 32'h0001_0001, 32'h0000_1234, 32'h0,        1'b1, 1, 0, 0};
    vecs[16] = '{1'b0, 3'b101, 32'h0001_0003, 32'h0,        32'h0,         1'b1, 1, 0, 0};
    vecs[17] = '{1'b0, 3'b011, 32'h0001_0000, 32'h0,        32'h0,         1'b1, 1, 0, 0};
    vecs[18] = '{1'b1, 3'b100, 32'h0001_0000, 32'h0000_0077, 32'h0,        1'b1, 1, 0, 0};
    vecs[19] = '{1'b0, 3'b010, 32'h0001_0004, 32'h0,        32'hDEAD_BEEF, 1'b0, 2, 1, 0};

    rst = 1'b1; preset = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; preset = 1'b0;
    #1;
    check32("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check32("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check32("rst_rsp_rdata", rsp_rdata, 32'h0);
    check32("rst_rsp_err",   {31'b0, rsp_err}, 32'd0);
    check32("rst_ram_de",    {31'b0, ram_de}, 32'd0);
    check32("rst_ram_we",    {31'b0, ram_we}, 32'd0);
    check32("rst_ram_a",     ram_a, 32'h0);
    check32("rst_ram_wd",    ram_wd, 32'h0);
    check32("rst_busy",      {31'b0, busy}, 32'd0);

    n_ld = 0; n_st = 0; n_er = 0;
    for (int i = 0; i < 20; i++) begin
      run_req(vecs[i], i);
      if (vecs[i].err) n_er++;
      else if (vecs[i].store) n_st++;
      else n_ld++;
      if (i == 8) begin
        check32("sb_ram_wd", last_wd, 32'h1122_AA44);
        check32("sb_ram_a",  last_wa, 32'h0001_0000);
      end
      if (i == 12) check32("sw_ram_a", last_wa, 32'h0001_0004);
    end

`ifdef DATA_MEM_CTRL_STATS_EN
    check32("stat_loads",  {30'b0, stat_loads},  {30'b0, sat(n_ld)});
    check32("stat_stores", {30'b0, stat_stores}, {30'b0, sat(n_st)});
    check32("stat_errs",   {30'b0, stat_errs},   {30'b0, sat(n_er)});
`else
    check32("stat_loads",  {30'b0, stat_loads},  32'd0);
    check32("stat_stores", {30'b0, stat_stores}, 32'd0);
    check32("stat_errs",   {30'b0, stat_errs},   32'd0);
`endif

    // Back-pressure: response must hold while rsp_ready is low.
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0001_0004;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check32($sformatf("hold_valid[%0d]", k), {31'b0, rsp_valid}, 32'd1);
      check32($sformatf("hold_rdata[%0d]", k), rsp_rdata, 32'hDEAD_BEEF);
      check32($sformatf("hold_ready[%0d]", k), {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check32("release_valid", {31'b0, rsp_valid}, 32'd0);
    check32("release_ready", {31'b0, req_ready}, 32'd1);

    // Abort: reset lands on the WRITE cycle of a byte store.
    we0 = wr_cnt;
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h0001_0004; req_wdata = 32'h0000_0011;
    @(negedge clk);
    req_valid = 1'b0;
    check32("abort_rmw_de", {31'b0, ram_de}, 32'd1);
    check32("abort_rmw_we", {31'b0, ram_we}, 32'd0);
    @(negedge clk);
    check32("abort_write_we", {31'b0, ram_we}, 32'd1);
    check32("abort_write_wd", ram_wd, 32'hDEAD_BE11);
    rst = 1'b1;
    #1;
    check32("abort_we_gated", {31'b0, ram_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check32("abort_req_ready", {31'b0, req_ready}, 32'd1);
    check32("abort_busy",      {31'b0, busy}, 32'd0);
    check32("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check32("abort_no_write",  32'(wr_cnt - we0), 32'd0);
    check32("abort_mem_kept",  mem[1], 32'hDEAD_BEEF);
    check32("abort_stat_loads", {30'b0, stat_loads}, 32'd0);
    check32("abort_stat_stores", {30'b0, stat_stores}, 32'd0);
    check32("abort_stat_errs", {30'b0, stat_errs}, 32'd0);

    check32("ram_pin_rules", 32'(bad_pin), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
